spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- SPI receive endpoint for the 12-bit write-only master link (cs active-low, sclk, mosi; MSB first; master updates mosi on sclk rising edge).
- Oversamples sclk/cs/mosi in the local clk domain, shifts in one frame per cs-low window, and presents the word in a holding register with a valid/ack handshake.
- Sits on the peripheral side, feeding a register file or command decoder.

Parameters:
- DATA_W, 12: frame length in bits; also the dout width.
- SYNC_STAGES, 2: synchronizer depth (≥2) applied identically to sclk, cs and mosi.

Ports:
- clk  in  1  system clock; must be ≥2x sclk, with each sclk phase lasting ≥1 clk.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  serial clock from master; may free-run while cs is high.
- cs  in  1  chip select, active-low.
- mosi  in  1  serial data, MSB first.
- rd_ack  in  1  consumer acknowledge; clears dout_valid.
- dout  out  DATA_W  last received word.
- dout_valid  out  1  high while dout holds an unacknowledged word.
- overrun  out  1  sticky: a word was overwritten before being acked.
- frame_err  out  1  one-clk pulse on a malformed frame (see optional feature).

Behaviour:
- Reset (async, rst=1): dout=0, dout_valid=0, overrun=0, frame_err=0, state=IDLE, bit_cnt=0, shift=0, synchronizers preset to sclk=0, cs=1, mosi=0.
- Synchronization:
  - sclk, cs and mosi each pass through SYNC_STAGES flops, so their relative alignment is preserved.
  - Edge detection uses one further registered copy of synced sclk.
  - fall = prev_sclk & ~sclk_s.
  - cs_fall and cs_rise are derived the same way from synced cs.
- State machine:
  - IDLE: on cs_fall, set bit_cnt=0 and shift=0, then go to RECV. sclk edges are ignored while cs_s=1.
  - RECV:
    - On each fall with cs_s=0: shift={shift[DATA_W-2:0], mosi_s}, bit_cnt++.
    - When bit_cnt reaches DATA_W (on the DATA_W-th fall), go to CMPL.
    - cs_rise while bit_cnt<DATA_W: short frame. Discard shift, go to IDLE, and flag frame_err (see optional feature).
  - CMPL (exactly one clk):
    - dout<=shift, dout_valid<=1.
    - If dout_valid was already 1 and rd_ack=0 in this cycle, set overrun<=1.
    - Then go to WAIT_CS.
  - WAIT_CS:
    - On cs_rise, go to IDLE.
    - Any further fall while cs_s=0 is a long frame: flag frame_err, stay in WAIT_CS. dout is not altered.
- Handshake:
  - rd_ack=1 with dout_valid=1 clears dout_valid next clk.
  - rd_ack in the same cycle as CMPL: the new word wins, and dout_valid stays 1.
  - rd_ack with dout_valid=0 has no effect.
  - overrun clears only on rst, or on rd_ack while dout_valid=1.
- Latency: dout_valid rises SYNC_STAGES+2 clk after the DATA_W-th sclk falling edge at the pins.
- Back-to-back frames: cs may fall in the same synced cycle as leaving WAIT_CS. The IDLE check on cs_fall must not miss it; cs_s low in IDLE counts as a start.
- A cs_fall seen in RECV is impossible. A glitch where cs rises and falls within one clk is treated as a short frame, followed by a new start.
- Reset mid-frame: everything returns to reset values immediately; the partial word is lost.

Optional Feature:
- Macro: SPI_SLAVE_RX_FRAME_ERR_EN.
- Defined: frame_err pulses high for one clk on a short frame (cs_rise in RECV) and on each extra fall in WAIT_CS.
- Undefined: frame_err is tied to 0. Short frames are still silently discarded and extra edges still ignored; state behaviour is identical.

Test Plan:
- Reset then a single frame 0xAAA at sclk=clk/2 -> dout=0xAAA, dout_valid=1, overrun=0, frame_err never high.
- Frames 0x5A5 then 0xFFF with no rd_ack -> dout=0xFFF, overrun=1; then rd_ack -> dout_valid=0, overrun=0.
- cs released after 7 bits of 0x123, then a full 0x800 -> frame_err pulses once (macro on) and dout=0x800. The short frame never asserts dout_valid.
- 13 sclk falls within one cs-low window for 0x001 -> dout=0x001, one frame_err pulse (macro on), frame_err stays 0 (macro off).
- rd_ack asserted in the same clk as CMPL of 0x3C3 with the prior word pending -> dout=0x3C3, dout_valid=1, overrun=0.
- rst asserted after 6 bits of 0xFFF, released, then a full 0x00F -> outputs at reset values during rst, then dout=0x00F with no residue from the first frame.

Source files
------------

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
// SPI receive endpoint for a write-only master link (cs active-low, MSB
// first, master drives mosi on the sclk rising edge, slave samples on the
// falling edge). sclk, cs and mosi are oversampled in the clk domain, one
// DATA_W-bit frame is shifted in per cs-low window, and the finished word is
// held in dout with a valid/ack handshake.
//
// Optional feature macro: SPI_SLAVE_RX_FRAME_ERR_EN
//   defined   : frame_err pulses for one clk on a short frame (cs released
//               before DATA_W bits) and on every extra sclk fall after the
//               DATA_W-th bit while cs stays low.
//   undefined : frame_err is tied low; frame handling is otherwise identical.
//
// Ports:
//   clk        in   system clock, at least 2x sclk, each sclk phase >= 1 clk
//   rst        in   asynchronous active-high reset
//   sclk       in   serial clock from master (may free-run while cs is high)
//   cs         in   chip select, active-low
//   mosi       in   serial data, MSB first
//   rd_ack     in   consumer acknowledge, clears dout_valid
//   dout       out  last received word
//   dout_valid out  dout holds an unacknowledged word
//   overrun    out  sticky: a word was overwritten before being acknowledged
//   frame_err  out  one-clk pulse on a malformed frame (see macro above)

module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CMPL,
        WAIT_CS
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   fall;
    logic                   cs_rise;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      shift;

    logic                   start;
    logic                   shift_en;
    logic                   load;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    logic                   err_set;
`endif

    // Synchronizer stage: identical depth on all three pins keeps the
    // mosi/sclk/cs alignment seen by the master.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign fall    = sclk_prev & ~sclk_s;
    assign cs_rise = ~cs_prev & cs_s;

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        load      = 1'b0;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        err_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Level test rather than edge test so a cs that drops in the
                // same cycle we leave WAIT_CS still starts a frame.
                if (!cs_s) begin
                    start     = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
                    err_set   = 1'b1;
`endif
                end else if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        state_nxt = CMPL;
                    end
                end
            end
            CMPL: begin
                load      = 1'b1;
                state_nxt = WAIT_CS;
            end
            WAIT_CS: begin
                // Leave on cs high (level) so a cs release that lands in the
                // CMPL cycle is not lost.
                if (cs_s) begin
                    state_nxt = IDLE;
                end else if (fall) begin
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
                    err_set = 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift stage: capture mosi on each synced sclk fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (start) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (shift_en) begin
            shift   <= {shift[DATA_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Holding stage: a completing word takes priority over an ack in the
    // same cycle, so the new word stays valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            dout       <= shift;
            dout_valid <= 1'b1;
            if (dout_valid) begin
                overrun <= ~rd_ack;
            end
        end else if (rd_ack && dout_valid) begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_set;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx. Frames are driven at the pins, and
// a transaction-level model predicts at which clk edge each word lands and
// each frame_err pulse appears; a compare process checks every cycle.

module tb_spi_slave_rx;

    localparam int DW = 12;
    localparam int SS = 2;

`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    localparam bit FERR_ON = 1'b1;
`else
    localparam bit FERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          cs;
    logic          mosi;
    logic          rd_ack;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          overrun;
    logic          frame_err;

    spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .rd_ack     (rd_ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int ferr_seen = 0;
    int ack_at = -1;
    bit rand_ack_en = 1'b0;

    typedef struct {
        int            due;
        bit            land;
        logic [DW-1:0] w;
    } ev_t;
    ev_t ev_q[$];

    logic [DW-1:0] m_dout;
    bit            m_valid;
    bit            m_ovr;
    bit            m_ferr;
    bit            landed;
    logic [DW-1:0] land_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: a word completed by the DATA_W-th fall at the pins lands
    // SS+2 edges later; a malformed-frame event shows as frame_err SS+1
    // edges after the offending pin change.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_dout  = '0;
                m_valid = 1'b0;
                m_ovr   = 1'b0;
                m_ferr  = 1'b0;
                ev_q.delete();
            end else begin
                landed = 1'b0;
                land_w = '0;
                m_ferr = 1'b0;
                for (int i = ev_q.size() - 1; i >= 0; i--) begin
                    if (ev_q[i].due == cyc) begin
                        if (ev_q[i].land) begin
                            landed = 1'b1;
                            land_w = ev_q[i].w;
                        end else begin
                            m_ferr = FERR_ON;
                        end
                        ev_q.delete(i);
                    end
                end
                if (landed) begin
                    if (m_valid) m_ovr = !rd_ack;
                    m_dout  = land_w;
                    m_valid = 1'b1;
                end else if (rd_ack && m_valid) begin
                    m_valid = 1'b0;
                    m_ovr   = 1'b0;
                end
            end
            #1;
            if (frame_err === 1'b1) ferr_seen++;
            check("dout", 32'(dout), 32'(m_dout));
            check("dout_valid", 32'(dout_valid), 32'(m_valid));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
        end
    end

    // rd_ack driver: a targeted ack at edge ack_at, or random acks.
    initial begin
        rd_ack = 1'b0;
        forever begin
            @(negedge clk);
            rd_ack = (cyc + 1 == ack_at) || (rand_ack_en && ($urandom_range(0, 5) == 0));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic push_ev(input int due, input bit land, input logic [DW-1:0] w);
        ev_t e;
        e.due  = due;
        e.land = land;
        e.w    = w;
        ev_q.push_back(e);
    endtask

    // One cs-low window with nbits sclk pulses, each phase ph clks long.
    task automatic send_frame(input logic [DW-1:0] w, input int nbits, input int ph, input bit ack_on_land);
        @(negedge clk) cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sclk = 1'b1;
            mosi = (i < DW) ? w[DW-1-i] : 1'($urandom_range(0, 1));
            repeat (ph - 1) @(negedge clk);
            @(negedge clk);
            sclk = 1'b0;
            if (i + 1 == DW) begin
                push_ev(cyc + SS + 2, 1'b1, w);
                if (ack_on_land) ack_at = cyc + SS + 2;
            end else if (i + 1 > DW) begin
                push_ev(cyc + SS + 1, 1'b0, '0);
            end
            repeat (ph - 1) @(negedge clk);
        end
        repeat ((nbits >= DW) ? 2 : 1) @(negedge clk);
        cs   = 1'b1;
        mosi = 1'b0;
        if (nbits < DW) push_ev(cyc + SS + 1, 1'b0, '0);
    endtask

    task automatic gap(input int n, input bit free_run);
        repeat (n) begin
            @(negedge clk);
            if (free_run) sclk = ~sclk;
        end
        @(negedge clk) sclk = 1'b0;
    endtask

    task automatic settle();
        repeat (SS + 4) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack_at = cyc + 2;
        repeat (3) @(negedge clk);
    endtask

    int f0;
    int kind;
    int nb;
    logic [DW-1:0] rw;
    logic [DW-1:0] pw;

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dout", 32'(dout), 32'h0);
        check("reset dout_valid", 32'(dout_valid), 32'h0);
        check("reset overrun", 32'(overrun), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        gap(2, 1'b0);

        // Single frame at sclk = clk/2.
        f0 = ferr_seen;
        send_frame(12'hAAA, DW, 1, 1'b0);
        settle();
        check("t1 dout", 32'(dout), 32'hAAA);
        check("t1 dout_valid", 32'(dout_valid), 32'h1);
        check("t1 overrun", 32'(overrun), 32'h0);
        check("t1 frame_err pulses", 32'(ferr_seen - f0), 32'h0);

        // Two unacked frames, then ack.
        send_frame(12'h5A5, DW, 2, 1'b0);
        gap(2, 1'b1);
        send_frame(12'hFFF, DW, 1, 1'b0);
        settle();
        check("t2 dout", 32'(dout), 32'hFFF);
        check("t2 overrun", 32'(overrun), 32'h1);
        pulse_ack();
        check("t2 ack dout_valid", 32'(dout_valid), 32'h0);
        check("t2 ack overrun", 32'(overrun), 32'h0);

        // Short frame (7 bits) then a full frame.
        f0 = ferr_seen;
        send_frame(12'h123, 7, 1, 1'b0);
        gap(1, 1'b0);
        settle();
        check("t3 short dout_valid", 32'(dout_valid), 32'h0);
        check("t3 short dout", 32'(dout), 32'hFFF);
        send_frame(12'h800, DW, 1, 1'b0);
        settle();
        check("t3 dout", 32'(dout), 32'h800);
        check("t3 frame_err pulses", 32'(ferr_seen - f0), 32'(FERR_ON ? 1 : 0));

        // Long frame: 13 falls.
        f0 = ferr_seen;
        send_frame(12'h001, DW + 1, 1, 1'b0);
        settle();
        check("t4 dout", 32'(dout), 32'h001);
        check("t4 frame_err pulses", 32'(ferr_seen - f0), 32'(FERR_ON ? 1 : 0));
        check("t4 overrun", 32'(overrun), 32'h1);

        // Ack in the completing cycle with a prior word pending.
        send_frame(12'h3C3, DW, 2, 1'b1);
        settle();
        check("t5 dout", 32'(dout), 32'h3C3);
        check("t5 dout_valid", 32'(dout_valid), 32'h1);
        check("t5 overrun", 32'(overrun), 32'h0);

        // Reset mid-frame after 6 bits of 0xFFF.
        @(negedge clk) cs = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sclk = 1'b1;
            mosi = 1'b1;
            @(negedge clk);
            sclk = 1'b0;
        end
        @(negedge clk);
        rst  = 1'b1;
        sclk = 1'b0;
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        check("t6 rst dout", 32'(dout), 32'h0);
        check("t6 rst dout_valid", 32'(dout_valid), 32'h0);
        check("t6 rst overrun", 32'(overrun), 32'h0);
        check("t6 rst frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        gap(2, 1'b0);
        send_frame(12'h00F, DW, 1, 1'b0);
        settle();
        check("t6 dout", 32'(dout), 32'h00F);
        check("t6 dout_valid", 32'(dout_valid), 32'h1);
        check("t6 overrun", 32'(overrun), 32'h0);

        // Randomized frames with random acks and free-running idle sclk.
        rand_ack_en = 1'b1;
        pw = '0;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            rw   = DW'($urandom);
            if (kind == 0)      nb = $urandom_range(1, DW - 1);
            else if (kind == 1) nb = $urandom_range(DW + 1, DW + 2);
            else                nb = DW;
            send_frame(rw, nb, $urandom_range(1, 3), 1'b0);
            gap($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            if (nb >= DW) pw = rw;
        end
        rand_ack_en = 1'b0;
        settle();
        check("rand last dout", 32'(dout), 32'(pw));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
